// File: rtl/vga_sincronizador.sv
// VGA raster timing generator: pixel-rate divider, x/y counters, registered sync/blank
// decode, DAC pixel clock and line/frame markers.
module vga_sincronizador #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic       vga_clk,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic [7:0]       frame_count_q, frame_count_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             blank_n_q, blank_n_d;
    logic             vga_clk_q, vga_clk_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             tick_s, x_wrap_s, frame_wrap_s;

    // Next-state logic: sync/blank/vga_clk decode from the *next* counters so they never lag x/y
    always_comb begin
        tick_s        = enable && (div_q == DIV_LAST);
        x_wrap_s      = tick_s && (x_q == X_LAST);
        frame_wrap_s  = x_wrap_s && (y_q == Y_LAST);
        div_d         = div_q;
        x_d           = x_q;
        y_d           = y_q;
        frame_count_d = frame_count_q;

        if (enable) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end else begin
            div_d = div_q;
        end

        if (tick_s) begin
            if (x_q == X_LAST) begin
                x_d = 10'd0;
            end else begin
                x_d = x_q + 10'd1;
            end
        end else begin
            x_d = x_q;
        end

        if (x_wrap_s) begin
            if (y_q == Y_LAST) begin
                y_d = 10'd0;
            end else begin
                y_d = y_q + 10'd1;
            end
        end else begin
            y_d = y_q;
        end

        if (frame_wrap_s) begin
            frame_count_d = frame_count_q + 8'd1;
        end else begin
            frame_count_d = frame_count_q;
        end

        hsync_d       = !((x_d >= HS_START) && (x_d < HS_END));
        vsync_d       = !((y_d >= VS_START) && (y_d < VS_END));
        blank_n_d     = (x_d < X_VIS) && (y_d < Y_VIS);
        vga_clk_d     = (div_d >= DIV_HALF);
        line_start_d  = x_wrap_s;
        frame_start_d = frame_wrap_s;
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q         <= '0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            frame_count_q <= 8'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_n_q     <= 1'b1;
            vga_clk_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_count_q <= frame_count_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_n_q     <= blank_n_d;
            vga_clk_q     <= vga_clk_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank_n     = blank_n_q;
    assign vga_clk     = vga_clk_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sincronizador.sv
// Scoreboard bench for vga_sincronizador on a reduced 12x7 raster (8x4 visible, CLK_DIV=2).
module tb_vga_sincronizador;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] fc;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       vc;
        logic       ls;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic [9:0] x_s, y_s;
    logic       hsync_s, vsync_s, blank_n_s, vga_clk_s, line_start_s, frame_start_s;
    logic [7:0] frame_count_s;

    exp_t sb_q[$];
    int   pix_m = 0;
    int   div_m = 0;
    bit   tick_m = 1'b0;
    bit   stats_on = 1'b1;
    bit   done = 1'b0;
    int   guard_fail = 0;

    int n_checks = 0;
    int n_fail = 0;
    int max_x = 0, max_y = 0, fs_count = 0;
    int hs_run = 0, hs_runs = 0, hs_bad = 0;
    int vs_run = 0, vs_runs = 0, vs_bad = 0;

    vga_sincronizador #(
        .H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .x(x_s), .y(y_s), .hsync(hsync_s), .vsync(vsync_s), .blank_n(blank_n_s),
        .vga_clk(vga_clk_s), .line_start(line_start_s), .frame_start(frame_start_s),
        .frame_count(frame_count_s)
    );

    always #5 clk = ~clk;

    // Reference raster derived from absolute pixel count: line 12 ticks, frame 7 lines
    function automatic exp_t model_out(input int pix, input int dv, input bit tk);
        exp_t e;
        int xm, ln, ym;
        xm = pix % 12;
        ln = pix / 12;
        ym = ln % 7;
        e.x  = 10'(xm);
        e.y  = 10'(ym);
        e.fc = 8'((ln / 7) % 256);
        e.hs = !(xm == 9 || xm == 10);
        e.vs = (ym != 5);
        e.bn = (xm < 8) && (ym < 4);
        e.vc = (dv >= 1);
        e.ls = tk && (xm == 0);
        e.fs = tk && (xm == 0) && (ym == 0);
        return e;
    endfunction

    task automatic step(input logic rst_v, input logic en_v);
        @(posedge clk);
        tick_m = 1'b0;
        if (reset && enable) begin
            if (div_m == 1) begin
                div_m  = 0;
                pix_m  = pix_m + 1;
                tick_m = 1'b1;
            end else begin
                div_m = div_m + 1;
            end
        end
        #2;
        reset  = rst_v;
        enable = en_v;
        if (!rst_v) begin
            pix_m  = 0;
            div_m  = 0;
            tick_m = 1'b0;
        end
        sb_q.push_back(model_out(pix_m, div_m, tick_m));
    endtask

    initial begin
        int n;
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        n = 0;
        while (!((pix_m % 12) == 5 && ((pix_m / 12) % 7) == 2 && pix_m >= 84 && div_m == 0)
               && n < 1000) begin
            step(1'b1, 1'b1);
            n++;
        end
        if (n >= 1000) begin
            guard_fail++;
            $display("FAIL guard_freeze_point got=%0d cycles required<1000", n);
        end
        repeat (37) step(1'b1, 1'b0);
        n = 0;
        while (pix_m < 257 * 84 && n < 50000) begin
            step(1'b1, 1'b1);
            n++;
        end
        n = 0;
        while (((pix_m / 12) % 7) != 5 && n < 500) begin
            step(1'b1, 1'b1);
            n++;
        end
        if (n >= 500) begin
            guard_fail++;
            $display("FAIL guard_vsync_row got=%0d cycles required<500", n);
        end
        stats_on = 1'b0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (50) step(1'b1, 1'b1);
        done = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got=expired required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // Monitor: pops one expectation per cycle, accumulates run statistics, closes the run
    always @(negedge clk) begin : mon
        exp_t e;
        exp_t o;
        o.x  = x_s;           o.y  = y_s;           o.fc = frame_count_s;
        o.hs = hsync_s;       o.vs = vsync_s;       o.bn = blank_n_s;
        o.vc = vga_clk_s;     o.ls = line_start_s;  o.fs = frame_start_s;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL sb_cycle t=%0t got x=%0d y=%0d fc=%0d hs/vs/bn/vc/ls/fs=%b%b%b%b%b%b required x=%0d y=%0d fc=%0d hs/vs/bn/vc/ls/fs=%b%b%b%b%b%b",
                         $time, o.x, o.y, o.fc, o.hs, o.vs, o.bn, o.vc, o.ls, o.fs,
                         e.x, e.y, e.fc, e.hs, e.vs, e.bn, e.vc, e.ls, e.fs);
            end
        end
        if (int'(x_s) > max_x) max_x = int'(x_s);
        if (int'(y_s) > max_y) max_y = int'(y_s);
        if (frame_start_s) fs_count++;
        if (stats_on) begin
            if (!hsync_s) begin
                hs_run++;
            end else if (hs_run != 0) begin
                hs_runs++;
                if (hs_run != 4) hs_bad++;
                hs_run = 0;
            end
            if (!vsync_s) begin
                vs_run++;
            end else if (vs_run != 0) begin
                vs_runs++;
                if (vs_run != 24) vs_bad++;
                vs_run = 0;
            end
        end
        if (done) begin
            chk("scoreboard_drained", sb_q.size(), 0);
            chk("guard_expired", guard_fail, 0);
            chk("max_x", max_x, 11);
            chk("max_y", max_y, 6);
            chk("frame_start_pulses", fs_count, 257);
            chk("hsync_runs_seen", (hs_runs > 100) ? 1 : 0, 1);
            chk("hsync_bad_run_len", hs_bad, 0);
            chk("vsync_runs_seen", (vs_runs >= 200) ? 1 : 0, 1);
            chk("vsync_bad_run_len", vs_bad, 0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

endmodule
